// File: rtl/hybrid_control_supervisor_if.sv
// Signal bundle between the parameter/UI side (master) and the converter supervisor (slave).
// No valid/ready handshake: every input is a level sampled on each clock, o_ready is a plain status flag.
interface hybrid_control_supervisor_if;
  logic               i_enable;
  logic               i_fault;
  logic signed [31:0] i_ZVS_target;
  logic signed [31:0] i_phi_target;
  logic        [3:0]  i_MOSFET_hc;
  logic               o_hc_RESET;
  logic signed [31:0] o_ZVS;
  logic signed [31:0] o_phi;
  logic        [3:0]  o_MOSFET;
  logic               o_ready;
  logic        [2:0]  o_state;

  modport master (
    output i_enable, i_fault, i_ZVS_target, i_phi_target, i_MOSFET_hc,
    input  o_hc_RESET, o_ZVS, o_phi, o_MOSFET, o_ready, o_state
  );

  modport slave (
    input  i_enable, i_fault, i_ZVS_target, i_phi_target, i_MOSFET_hc,
    output o_hc_RESET, o_ZVS, o_phi, o_MOSFET, o_ready, o_state
  );
endinterface

// File: rtl/hybrid_control_supervisor.sv
// Start/stop/fault sequencer for the hybrid resonant controller: soft-ramps the ZVS/phi angles
// and gates the four MOSFET commands with per-switch turn-on dead-time.
module hybrid_control_supervisor #(
  parameter logic        [31:0] RAMP_DIV  = 32'd1000,
  parameter logic        [31:0] RAMP_STEP = 32'd1,
  parameter logic signed [31:0] START_ZVS = 32'sd10,
  parameter logic signed [31:0] START_PHI = 32'sd0,
  parameter logic        [31:0] START_CYC = 32'd5000,
  parameter logic        [7:0]  DEADTIME  = 8'd8
) (
  input logic                       i_clock,
  input logic                       i_RESET,
  hybrid_control_supervisor_if.slave bus
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RAMP  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic        [2:0]  state;
  logic               hc_reset;
  logic               ready;
  logic signed [31:0] zvs;
  logic signed [31:0] phi;
  logic        [3:0]  mosfet;
  logic        [31:0] start_cnt;
  logic        [31:0] div_cnt;
  logic        [7:0]  dt_cnt [4];

  logic active;
  logic at_target;
  logic keep_gates;

  // One ramp step toward tgt; the 33-bit difference keeps extreme angle pairs from wrapping.
  function automatic logic signed [31:0] step_toward(input logic signed [31:0] cur,
                                                     input logic signed [31:0] tgt);
    logic signed [32:0] diff;
    logic signed [32:0] lim;
    diff = {tgt[31], tgt} - {cur[31], cur};
    lim  = $signed({1'b0, RAMP_STEP});
    if (diff > lim)       return cur + $signed(RAMP_STEP);
    else if (diff < -lim) return cur - $signed(RAMP_STEP);
    else                  return tgt;
  endfunction

  assign active     = (state == ST_START) || (state == ST_RAMP) || (state == ST_RUN);
  assign at_target  = (zvs == bus.i_ZVS_target) && (phi == bus.i_phi_target);
  assign keep_gates = active && bus.i_enable && !bus.i_fault;

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state     <= ST_IDLE;
      hc_reset  <= 1'b0;
      ready     <= 1'b0;
      zvs       <= START_ZVS;
      phi       <= START_PHI;
      start_cnt <= '0;
      div_cnt   <= '0;
    end else if (bus.i_fault || (active && !bus.i_enable)) begin
      // Fault outranks disable; both drop the controller into reset with start angles.
      state     <= bus.i_fault ? ST_FAULT : ST_IDLE;
      hc_reset  <= 1'b0;
      ready     <= 1'b0;
      zvs       <= START_ZVS;
      phi       <= START_PHI;
      start_cnt <= '0;
      div_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          zvs <= START_ZVS;
          phi <= START_PHI;
          if (bus.i_enable) begin
            state     <= ST_START;
            hc_reset  <= 1'b1;
            start_cnt <= '0;
          end
        end
        ST_START: begin
          if (start_cnt == START_CYC - 32'd1) begin
            state     <= ST_RAMP;
            start_cnt <= '0;
            div_cnt   <= '0;
          end else begin
            start_cnt <= start_cnt + 32'd1;
          end
        end
        ST_RAMP: begin
          if (at_target) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else if (div_cnt == RAMP_DIV - 32'd1) begin
            div_cnt <= '0;
            zvs     <= step_toward(zvs, bus.i_ZVS_target);
            phi     <= step_toward(phi, bus.i_phi_target);
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          if (!at_target) begin
            state   <= ST_RAMP;
            ready   <= 1'b0;
            div_cnt <= '0;
          end
        end
        ST_FAULT: begin
          // Latched: only a cycle with fault low and enable low releases it.
          if (!bus.i_enable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Turn-on delay per switch; a command that drops mid-count forfeits the whole delay.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      mosfet <= '0;
      for (int i = 0; i < 4; i++) dt_cnt[i] <= '0;
    end else if (!keep_gates) begin
      mosfet <= '0;
      for (int i = 0; i < 4; i++) dt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.i_MOSFET_hc[i]) begin
          mosfet[i] <= 1'b0;
          dt_cnt[i] <= '0;
        end else if (!mosfet[i]) begin
          if (dt_cnt[i] == DEADTIME) mosfet[i] <= 1'b1;
          else                       dt_cnt[i] <= dt_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign bus.o_state    = state;
  assign bus.o_hc_RESET = hc_reset;
  assign bus.o_ready    = ready;
  assign bus.o_ZVS      = zvs;
  assign bus.o_phi      = phi;
  assign bus.o_MOSFET   = mosfet;
endmodule
